// File: rtl/cpu6_bus_pkg.sv
// cpu6_bus_pkg: shared types and constants for the CPU6 external bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu6_bus_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    // Port IDs double as the index into the {dma, cpu} request vector.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Read data returned when a slow device never answers.
    localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } bus_state_e;

    // Everything captured from the winning requester at the grant edge.
    typedef struct packed {
        logic              owner;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick between the CPU and DMA request levels.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req_i[1:0] request levels {dma, cpu}; last_owner_i most recently served port;
//        gnt_id_o chosen port ID; gnt_vld_o high when any request is present.
module rr_arbiter2
    import cpu6_bus_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic       gnt_id_o,
    output logic       gnt_vld_o
);

    always_comb begin
        gnt_vld_o = |req_i;
        // On a tie the port that was not served last wins; with a single
        // request req_i[1] directly names it (10 -> DMA, 01 -> CPU).
        if (req_i == 2'b11) begin
            gnt_id_o = ~last_owner_i;
        end else begin
            gnt_id_o = req_i[1] ? PORT_DMA : PORT_CPU;
        end
    end

endmodule

// File: rtl/bus_cycle_arbiter.sv
// bus_cycle_arbiter: owns the CPU6 external memory bus and runs one CPU or DMA transfer at a time.
// Latency: ack 3 cycles after the request-sampling edge, +1 per wait state and per mem_ready-low cycle.
// Backpressure: req is a level held until its ack pulse; mem_ready low stalls the strobe phase.
// Ports: clock/reset (synchronous, active-high); cpu_* and dma_* requester ports with one-cycle
//        acks; rdata/bus_err completion results; addressBus, data_out, data_oe, mem_rd, mem_wr
//        drive the external bus, data_in and mem_ready come back from it.
// Optional: define BUS_TIMEOUT_EN to end a strobe after TIMEOUT_CYCLES cycles of mem_ready low
//           (reads return 8'hFF, bus_err pulses with the ack).
module bus_cycle_arbiter
    import cpu6_bus_pkg::*;
#(
    parameter int unsigned WAIT_STATES    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              bus_err,
    output logic [ADDR_W-1:0] addressBus,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic [DATA_W-1:0] data_in,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ready
);

    bus_state_e        state_q, state_d;
    bus_req_t          req_q, req_d;
    logic              last_owner_q, last_owner_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              gnt_id;
    logic              gnt_vld;
    bus_req_t          gnt_req;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              err_q, err_d;
`endif

    rr_arbiter2 u_rr (
        .req_i        ({dma_req, cpu_req}),
        .last_owner_i (last_owner_q),
        .gnt_id_o     (gnt_id),
        .gnt_vld_o    (gnt_vld)
    );

    // Select the winning requester's transfer fields.
    always_comb begin
        gnt_req.owner = gnt_id;
        if (gnt_id == PORT_DMA) begin
            gnt_req.we    = dma_we;
            gnt_req.addr  = dma_addr;
            gnt_req.wdata = dma_wdata;
        end else begin
            gnt_req.we    = cpu_we;
            gnt_req.addr  = cpu_addr;
            gnt_req.wdata = cpu_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        last_owner_d = last_owner_q;
        wait_cnt_d   = wait_cnt_q;
        rdata_d      = rdata_q;
`ifdef BUS_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        err_d        = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Requester inputs are only looked at on this edge.
                if (gnt_vld) begin
                    req_d   = gnt_req;
                    state_d = ADDR;
`ifdef BUS_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ADDR: begin
                wait_cnt_d = 4'(WAIT_STATES);
`ifdef BUS_TIMEOUT_EN
                to_cnt_d   = '0;
`endif
                state_d    = ACCESS;
            end
            ACCESS: begin
                // mem_ready is ignored until the minimum strobe width has elapsed.
                if (wait_cnt_q != 4'd0) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end else if (mem_ready) begin
                    if (!req_q.we) begin
                        rdata_d = data_in;
                    end
                    state_d = DONE;
                end
`ifdef BUS_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // This is the TIMEOUT_CYCLES-th ready-low cycle: give up.
                    if (!req_q.we) begin
                        rdata_d = TIMEOUT_RDATA;
                    end
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
`endif
            end
            DONE: begin
                last_owner_d = req_q.owner;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            req_q        <= '0;
            last_owner_q <= PORT_DMA;
            wait_cnt_q   <= '0;
            rdata_q      <= '0;
`ifdef BUS_TIMEOUT_EN
            to_cnt_q     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            last_owner_q <= last_owner_d;
            wait_cnt_q   <= wait_cnt_d;
            rdata_q      <= rdata_d;
`ifdef BUS_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    // Address and write data come straight from the latched request, so they
    // are stable from ADDR (one cycle before the strobe) through DONE.
    assign addressBus = req_q.addr;
    assign data_out   = req_q.wdata;
    assign data_oe    = req_q.we && ((state_q == ADDR) || (state_q == ACCESS));
    assign mem_rd     = (state_q == ACCESS) && !req_q.we;
    assign mem_wr     = (state_q == ACCESS) && req_q.we;
    assign cpu_ack    = (state_q == DONE) && (req_q.owner == PORT_CPU);
    assign dma_ack    = (state_q == DONE) && (req_q.owner == PORT_DMA);
    assign rdata      = rdata_q;
`ifdef BUS_TIMEOUT_EN
    assign bus_err    = (state_q == DONE) && err_q;
`else
    assign bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// tb_bus_cycle_arbiter: directed and random transfers checked against a transaction-timeline model.
// Latency: n/a.
// Backpressure: the bench plays both requesters and a memory with random ready stalls.
module tb_bus_cycle_arbiter;

    localparam int WS = 2;
    localparam int TO = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_wdata = 8'h0;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [15:0] dma_addr = 16'h0;
    logic [7:0]  dma_wdata = 8'h0;
    logic [7:0]  data_in = 8'h0;
    logic        mem_ready = 1'b0;
    logic        cpu_ack, dma_ack, bus_err, data_oe, mem_rd, mem_wr;
    logic [7:0]  rdata, data_out;
    logic [15:0] addressBus;

    always #5 clock = ~clock;

    bus_cycle_arbiter #(.WAIT_STATES(WS), .TIMEOUT_CYCLES(TO)) u_dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
        .rdata(rdata), .bus_err(bus_err), .addressBus(addressBus), .data_out(data_out), .data_oe(data_oe),
        .data_in(data_in), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ready(mem_ready)
    );

    // One pending transfer; 'low' is how many ready-low cycles the memory
    // inserts after the wait states have expired.
    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          low;
    } txn_t;

    txn_t        pq [2][$];          // per-port request queues, index = port ID
    logic [7:0]  mem [logic [15:0]];
    int          ack_log [$];        // order of acks actually seen on the DUT

    int          n_chk = 0, n_err = 0, c = 0;
    bit          act = 0, exp_err = 0;
    int          own = 0, t_g = 0, t_ack = 0, last = 1, free_from = 0;
    txn_t        cur;
    logic [7:0]  exp_rdata = 8'h00;
    logic [15:0] bus_addr = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
        end
    endtask

    function automatic logic [7:0] memval(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic push(input int p, input logic we, input logic [15:0] a, input logic [7:0] d, input int low);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.low = low;
        pq[p].push_back(t);
    endtask

    // One clock cycle: check outputs at the falling edge, advance the model,
    // then drive requesters and memory for the next rising edge.
    task automatic step(input bit rst);
        logic        e_rd, e_wr, e_oe, e_ca, e_da, e_er, rdy;
        logic [15:0] e_ad;
        int          k;
        @(negedge clock);
        c++;
        e_rd = 0; e_wr = 0; e_oe = 0; e_ca = 0; e_da = 0; e_er = 0; e_ad = bus_addr;
        if (act) begin
            if (c == t_g + 1) begin
                e_oe = cur.we;
            end else if (c < t_ack) begin
                e_rd = !cur.we; e_wr = cur.we; e_oe = cur.we;
            end else if (c == t_ack) begin
                e_ca = (own == 0); e_da = (own == 1); e_er = exp_err;
                if (!cur.we) exp_rdata = exp_err ? 8'hFF : memval(cur.addr);
                else if (!exp_err) mem[cur.addr] = cur.wdata;
            end
        end
        if (cpu_ack === 1'b1) ack_log.push_back(0);
        if (dma_ack === 1'b1) ack_log.push_back(1);
        chk("mem_rd", 32'(mem_rd), 32'(e_rd));
        chk("mem_wr", 32'(mem_wr), 32'(e_wr));
        chk("data_oe", 32'(data_oe), 32'(e_oe));
        chk("cpu_ack", 32'(cpu_ack), 32'(e_ca));
        chk("dma_ack", 32'(dma_ack), 32'(e_da));
        chk("bus_err", 32'(bus_err), 32'(e_er));
        chk("addressBus", 32'(addressBus), 32'(e_ad));
        chk("rdata", 32'(rdata), 32'(exp_rdata));
        if (e_oe) chk("data_out", 32'(data_out), 32'(cur.wdata));

        if (act && c == t_ack) begin
            act = 0; last = own; free_from = c + 1;
            void'(pq[own].pop_front());
        end

        if (rst) begin
            if (act) void'(pq[own].pop_front());
            act = 0; last = 1; bus_addr = 16'h0; exp_rdata = 8'h0; free_from = c + 1;
        end else if (!act && c >= free_from && (pq[0].size() > 0 || pq[1].size() > 0)) begin
            if (pq[0].size() > 0 && pq[1].size() > 0) own = (last == 0) ? 1 : 0;
            else own = (pq[0].size() > 0) ? 0 : 1;
            cur = pq[own][0]; act = 1; t_g = c; bus_addr = cur.addr; exp_err = 0;
`ifdef BUS_TIMEOUT_EN
            if (cur.low >= TO) begin
                exp_err = 1; t_ack = c + 2 + WS + TO;
            end else
`endif
            t_ack = c + 3 + WS + cur.low;
        end

        reset   = rst;
        cpu_req = (pq[0].size() > 0);
        dma_req = (pq[1].size() > 0);
        // Once latched, the owner's fields are scrambled to prove they are ignored.
        if (pq[0].size() > 0 && !(act && own == 0 && c > t_g)) begin
            cpu_we = pq[0][0].we; cpu_addr = pq[0][0].addr; cpu_wdata = pq[0][0].wdata;
        end else begin
            cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
        end
        if (pq[1].size() > 0 && !(act && own == 1 && c > t_g)) begin
            dma_we = pq[1][0].we; dma_addr = pq[1][0].addr; dma_wdata = pq[1][0].wdata;
        end else begin
            dma_we = 1'($urandom); dma_addr = 16'($urandom); dma_wdata = 8'($urandom);
        end

        rdy = 1'($urandom);
        k = -1;
        if (act && c >= t_g + 2) begin
            k = c - t_g - 2;
            if (k >= WS) rdy = (k >= WS + cur.low);
        end
        mem_ready = rdy;
        data_in   = (k >= WS && rdy) ? memval(cur.addr) : 8'($urandom);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((act || pq[0].size() > 0 || pq[1].size() > 0) && n < budget) begin
            step(0);
            n++;
        end
        n_chk++;
        assert (!(act || pq[0].size() > 0 || pq[1].size() > 0)) else begin
            n_err++;
            $error("FAIL drain_budget cycle=%0d observed=busy expected=idle", c);
        end
        step(0);
    endtask

    initial begin
        int a0;
        // Reset: every output must read zero.
        step(1); step(1); step(1);

        // Single CPU read.
        mem[16'h1234] = 8'hA5;
        push(0, 1'b0, 16'h1234, 8'h00, 0);
        drain(50);
        chk("cpu_read_rdata", 32'(rdata), 32'h0000_00A5);

        // DMA write, then DMA read-back (leaves DMA as last owner).
        push(1, 1'b1, 16'h8000, 8'h3C, 0);
        drain(50);
        push(1, 1'b0, 16'h8000, 8'h00, 1);
        drain(50);
        chk("dma_readback", 32'(rdata), 32'h0000_003C);

        // Both ports held for four transfers: CPU, DMA, CPU, DMA.
        a0 = ack_log.size();
        push(0, 1'b0, 16'h0010, 8'h00, 0);
        push(1, 1'b1, 16'h0020, 8'h11, 1);
        push(0, 1'b1, 16'h0030, 8'h22, 0);
        push(1, 1'b0, 16'h0010, 8'h00, 2);
        drain(100);
        chk("rr_count", 32'(ack_log.size() - a0), 32'd4);
        for (int i = 0; i < 4 && a0 + i < ack_log.size(); i++)
            chk("rr_order", 32'(ack_log[a0 + i]), 32'(i % 2));

        // Read stalled five cycles past the wait states.
        push(0, 1'b0, 16'h0042, 8'h00, 5);
        drain(50);
        chk("stall_rdata", 32'(rdata), 32'(8'h42 ^ 8'h00 ^ 8'h5A));

        // Random traffic on both ports.
        for (int i = 0; i < 80; i++) begin
            for (int p = 0; p < 2; p++)
                if (pq[p].size() < 2 && $urandom_range(0, 3) == 0)
                    push(p, 1'($urandom), 16'h0100 + 16'($urandom_range(0, 7)), 8'($urandom),
                         int'($urandom_range(0, 3)));
            step(0);
        end
        drain(500);

        // Memory never answers.
        push(1, 1'b0, 16'h0BAD, 8'h00, 100000);
`ifdef BUS_TIMEOUT_EN
        drain(100);
        chk("timeout_rdata", 32'(rdata), 32'h0000_00FF);
`else
        for (int i = 0; i < 100; i++) step(0);
        // Abort in the middle of the strobe, then prove the bus is usable again.
        step(1);
        step(0);
        push(0, 1'b0, 16'h1234, 8'h00, 0);
        drain(50);
        chk("after_reset_rdata", 32'(rdata), 32'h0000_00A5);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_cycle_arbiter.md
Name: bus_cycle_arbiter

Overview:
- Owns the CPU6 external memory bus: the 16-bit address bus, the 8-bit data bus and the read/write strobes.
- Shares the bus between two requesters: the CPU microcode memory port (port 0) and a DMA channel (port 1).
- Each granted request is run as a sequenced bus cycle (address setup, strobe with wait states, completion).
- Arbitration is round-robin; one transfer is in flight at a time.

Parameters:
- WAIT_STATES, 1, minimum strobe cycles inserted before mem_ready is honoured (0..15).
- TIMEOUT_CYCLES, 15, cycles allowed for mem_ready after wait states expire (used only with BUS_TIMEOUT_EN).

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high.
- cpu_req  input  1  CPU requests a transfer (level).
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  16  CPU transfer address.
- cpu_wdata  input  8  CPU write data.
- cpu_ack  output  1  one-cycle completion pulse to CPU.
- dma_req  input  1  DMA requests a transfer (level).
- dma_we  input  1  1 = write, 0 = read.
- dma_addr  input  16  DMA transfer address.
- dma_wdata  input  8  DMA write data.
- dma_ack  output  1  one-cycle completion pulse to DMA.
- rdata  output  8  read data; valid while either ack is high, otherwise holds.
- bus_err  output  1  pulses with ack on a timed-out cycle.
- addressBus  output  16  external address.
- data_out  output  8  external write data.
- data_oe  output  1  drive enable for data_out onto dataBus.
- data_in  input  8  external read data.
- mem_rd  output  1  read strobe.
- mem_wr  output  1  write strobe.
- mem_ready  input  1  memory ready (slow devices hold low).

Behaviour:
- Reset values: state IDLE; every output 0 (addressBus 0, rdata 0); last_owner = DMA, so the CPU wins the first tie. Reset in any state aborts the cycle: strobes drop and no ack is issued.
- IDLE:
  - Sample the requests. If exactly one is high, grant it. If both are high, grant the port that is not last_owner.
  - Latch owner, we, addr and wdata, then go to ADDR. Requester inputs are ignored after the latch edge.
- ADDR (1 cycle):
  - addressBus = latched address; strobes low.
  - For a write, data_out is valid and data_oe = 1.
  - Load wait_cnt = WAIT_STATES; go to ACCESS.
- ACCESS:
  - mem_rd = !we, mem_wr = we; addressBus, data_out and data_oe held.
  - While wait_cnt != 0, decrement it and ignore mem_ready.
  - When wait_cnt == 0 and mem_ready = 1: for a read, latch rdata from data_in; go to DONE.
- DONE (1 cycle):
  - Strobes and data_oe low; addressBus held.
  - Owner's ack = 1; last_owner = owner; go to IDLE.
- Latency: with WAIT_STATES = 0 and mem_ready tied high, ack is high in the 3rd cycle after the request-sampling edge (IDLE→ADDR→ACCESS→DONE). Each wait state or ready-low cycle adds one cycle.
- Requester rule: deassert req on the edge at which ack is seen. A req still high in the following IDLE cycle is a new transfer.
- Fairness: under continuous requests from both ports, grants alternate CPU, DMA, CPU, …; neither port is starved.
- Exactly one of cpu_ack/dma_ack may be high in any cycle. mem_rd and mem_wr are never high together.
- Address and data are stable one full cycle before a strobe rises and while it is high (setup and hold guaranteed).

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - After wait_cnt reaches 0, a timeout counter counts ACCESS cycles with mem_ready low.
  - On reaching TIMEOUT_CYCLES, go to DONE with rdata = 8'hFF (reads; writes leave rdata unchanged) and bus_err = 1 for the ack cycle.
  - The timeout counter clears on every ADDR entry.
- BUS_TIMEOUT_EN undefined: ACCESS waits indefinitely for mem_ready; bus_err is constant 0; no timeout counter.

Decomposition:
- Package cpu6_bus_pkg:
  - State encoding (IDLE, ADDR, ACCESS, DONE).
  - Port ID constants (PORT_CPU = 0, PORT_DMA = 1).
  - Timeout read value 8'hFF.
  - Widths: address 16, data 8.
- Sub-module rr_arbiter2: combinational two-way round-robin pick from req[1:0] and last_owner, producing grant ID and grant-valid.

Test Plan:
- Single CPU read, WAIT_STATES = 0, mem_ready = 1, addr 16'h1234, data_in 8'hA5 → mem_rd high for exactly 1 cycle, cpu_ack in 3rd cycle after sample, rdata = 8'hA5, dma_ack never high.
- DMA write, addr 16'h8000, wdata 8'h3C, WAIT_STATES = 2 → data_oe from ADDR through ACCESS, mem_wr high 3 cycles, dma_ack pulses once, data_out = 8'h3C throughout.
- CPU and DMA requests raised in the same cycle and held for 4 transfers → grant order CPU, DMA, CPU, DMA; acks never overlap.
- Read with mem_ready held low 5 cycles past the wait states → ack delayed 5 cycles; rdata captured only on the ready cycle.
- Reset asserted mid-ACCESS → next cycle all strobes and acks 0, state IDLE; a subsequent request completes normally.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES = 15 and mem_ready stuck low → ack and bus_err pulse together, rdata = 8'hFF; without the macro, no ack after 100 cycles.
